// File: rtl/line_mem_pkg.sv
// Shared widths and FSM state encoding for the line_memory off-chip memory model.
package line_mem_pkg;

    localparam int LINE_W   = 256;
    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 5;
    localparam int LINE_AW  = ADDR_W - OFFSET_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/line_mem_array.sv
// DEPTH x 256-bit line storage with one synchronous port; the read register
// holds its value until the next read enable.
module line_mem_array
    import line_mem_pkg::*;
#(
    parameter int DEPTH = 512,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  index,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata
);

    logic [LINE_W-1:0] mem [DEPTH];

    // Storage is deliberately not reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[index] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[index];
        end
    end

endmodule

// File: rtl/line_memory.sv
// Fixed-latency 256-bit line memory behind the data cache refill/write-back port.
// Optional LINE_MEM_BOUNDS_EN flags and suppresses accesses beyond DEPTH lines.
module line_memory
    import line_mem_pkg::*;
#(
    parameter int DEPTH   = 512,
    parameter int LATENCY = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] data_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o,
    output logic              busy_o,
    output logic              err_o,
    output state_t            state_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY);
`ifdef LINE_MEM_BOUNDS_EN
    localparam int REQ_W = LINE_AW;
`else
    localparam int REQ_W = IDX_W;
`endif

    // Handshake: a request is taken only in IDLE when enable_i is high at a
    // rising edge; the requester keeps it up until ack_o, which pulses for one
    // cycle, after which at least one IDLE cycle passes before the next accept.
    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [REQ_W-1:0]   req_line;
    logic               req_write;
    logic [LINE_W-1:0]  req_data;
    logic [IDX_W-1:0]   req_idx;
    logic               req_oob;
    logic               commit;
    logic               arr_we;
    logic               arr_re;
    logic [LINE_W-1:0]  arr_rdata;
    logic               addr_unused;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && state == IDLE && enable_i) begin
            req_line  <= addr_i[OFFSET_W +: REQ_W];
            req_write <= write_i;
            req_data  <= data_i;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (enable_i) begin
                    state_nxt = BUSY;
                    cnt_nxt   = CNT_W'(LATENCY - 2);
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_nxt = ACK;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The array is touched only on the BUSY->ACK edge; reset on that edge
    // must discard the pending write.
    assign commit = (state == BUSY) && (cnt == '0) && !rst_i;
    assign arr_we = commit && req_write && !req_oob;
    assign arr_re = commit && !req_write && !req_oob;

`ifdef LINE_MEM_BOUNDS_EN
    logic rd_zero;

    assign req_idx     = req_line[IDX_W-1:0];
    assign req_oob     = (req_line >= LINE_AW'(DEPTH));
    assign addr_unused = ^addr_i[OFFSET_W-1:0];

    // Out-of-range reads return zero until the next read completes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_zero <= 1'b0;
        end else if (commit && !req_write) begin
            rd_zero <= req_oob;
        end
    end

    assign data_o = rd_zero ? '0 : arr_rdata;
    assign err_o  = (state == ACK) && req_oob;
`else
    assign req_idx     = req_line;
    assign req_oob     = 1'b0;
    assign addr_unused = ^{addr_i[ADDR_W-1:OFFSET_W+IDX_W], addr_i[OFFSET_W-1:0]};
    assign data_o      = arr_rdata;
    assign err_o       = 1'b0;
`endif

    line_mem_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .clk   (clk_i),
        .rst   (rst_i),
        .we    (arr_we),
        .re    (arr_re),
        .index (req_idx),
        .wdata (req_data),
        .rdata (arr_rdata)
    );

    assign ack_o   = (state == ACK);
    assign busy_o  = (state != IDLE);
    assign state_o = state;

endmodule
